// File: rtl/shape_driver_pkg.sv
// Shared state type, default playfield geometry and mask rotation for the shape driver.
package shape_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DROP,
        ST_LOCK
    } state_t;

    localparam int unsigned CELL       = 16;
    localparam int unsigned FIELD_X0   = 240;
    localparam int unsigned FIELD_Y0   = 80;
    localparam int unsigned COLS       = 10;
    localparam int unsigned ROWS       = 20;
    localparam int unsigned FALL_TICKS = 30;

    localparam logic [3:0] SPAWN_COL = 4'd4;
    localparam logic [4:0] SPAWN_ROW = 5'd1;

    // Clockwise quarter turn about the pivot cell.
    function automatic logic [8:0] rotate_cw(input logic [8:0] m);
        logic [8:0] r;
        r[6] = m[0];
        r[3] = m[1];
        r[0] = m[2];
        r[7] = m[3];
        r[4] = m[4];
        r[1] = m[5];
        r[8] = m[6];
        r[5] = m[7];
        r[2] = m[8];
        return r;
    endfunction

endpackage

// File: rtl/shape_bounds.sv
// Combinational legality check of a 3x3 mask placed at a candidate pivot cell.
module shape_bounds #(
    parameter int unsigned COLS = shape_driver_pkg::COLS,
    parameter int unsigned ROWS = shape_driver_pkg::ROWS
) (
    input  logic [8:0] i_mask,
    input  logic [4:0] i_col,
    input  logic [5:0] i_row,
    output logic       o_legal
);

    logic w_l;
    logic w_r;
    logic w_t;
    logic w_b;

    assign w_l = |i_mask[2:0];
    assign w_r = |i_mask[8:6];
    assign w_t = i_mask[0] | i_mask[3] | i_mask[6];
    assign w_b = i_mask[2] | i_mask[5] | i_mask[8];

    // Candidates one column left of 0 wrap to 31 and fail the right-edge test.
    assign o_legal = (i_col >= {4'b0, w_l})
                  && (({1'b0, i_col} + {5'b0, w_r}) <= 6'(COLS - 1))
                  && (i_row >= {5'b0, w_t})
                  && (({1'b0, i_row} + {6'b0, w_b}) <= 7'(ROWS - 1));

endmodule

// File: rtl/shape_driver.sv
// Falling-shape controller: spawn, gravity, move/rotate, hard drop and lock.
module shape_driver #(
    parameter int unsigned CELL       = shape_driver_pkg::CELL,
    parameter int unsigned FIELD_X0   = shape_driver_pkg::FIELD_X0,
    parameter int unsigned FIELD_Y0   = shape_driver_pkg::FIELD_Y0,
    parameter int unsigned COLS       = shape_driver_pkg::COLS,
    parameter int unsigned ROWS       = shape_driver_pkg::ROWS,
    parameter int unsigned FALL_TICKS = shape_driver_pkg::FALL_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       spawn_valid,
    input  logic [8:0] spawn_shape,
    output logic       spawn_ready,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_drop,
    output logic [9:0] x_shape,
    output logic [9:0] y_shape,
    output logic [8:0] blockNeighbors,
    output logic       landed
);

    import shape_driver_pkg::*;

    localparam int unsigned CW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [8:0]      r_mask;
    logic [8:0]      w_mask_nxt;
    logic [3:0]      r_pc;
    logic [3:0]      w_pc_nxt;
    logic [4:0]      r_pr;
    logic [4:0]      w_pr_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [9:0]      w_x_nxt;
    logic [9:0]      w_y_nxt;
    logic [8:0]      w_rot_mask;
    logic            w_grav;
    logic            w_down_ok;
    logic            w_left_ok;
    logic            w_right_ok;
    logic            w_rot_ok;

    assign w_rot_mask = rotate_cw(r_mask);
    assign w_grav     = tick && (r_cnt == CW'(FALL_TICKS - 1));

    shape_bounds #(.COLS(COLS), .ROWS(ROWS)) u_down (
        .i_mask (r_mask),
        .i_col  ({1'b0, r_pc}),
        .i_row  ({1'b0, r_pr} + 6'd1),
        .o_legal(w_down_ok)
    );

    shape_bounds #(.COLS(COLS), .ROWS(ROWS)) u_left (
        .i_mask (r_mask),
        .i_col  ({1'b0, r_pc} - 5'd1),
        .i_row  ({1'b0, r_pr}),
        .o_legal(w_left_ok)
    );

    shape_bounds #(.COLS(COLS), .ROWS(ROWS)) u_right (
        .i_mask (r_mask),
        .i_col  ({1'b0, r_pc} + 5'd1),
        .i_row  ({1'b0, r_pr}),
        .o_legal(w_right_ok)
    );

    shape_bounds #(.COLS(COLS), .ROWS(ROWS)) u_rot (
        .i_mask (w_rot_mask),
        .i_col  ({1'b0, r_pc}),
        .i_row  ({1'b0, r_pr}),
        .o_legal(w_rot_ok)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_pc_nxt    = r_pc;
        w_pr_nxt    = r_pr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (spawn_valid && (spawn_shape != '0)) begin
                    w_mask_nxt  = spawn_shape;
                    w_pc_nxt    = SPAWN_COL;
                    w_pr_nxt    = SPAWN_ROW;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (tick) begin
                    w_cnt_nxt = w_grav ? '0 : r_cnt + CW'(1);
                end
                // A due gravity step swallows any command sampled in the same cycle.
                if (w_grav) begin
                    if (w_down_ok) w_pr_nxt = r_pr + 5'd1;
                    else           w_state_nxt = ST_LOCK;
                end else if (btn_rot) begin
                    if (w_rot_ok) w_mask_nxt = w_rot_mask;
                end else if (btn_left) begin
                    if (w_left_ok) w_pc_nxt = r_pc - 4'd1;
                end else if (btn_right) begin
                    if (w_right_ok) w_pc_nxt = r_pc + 4'd1;
                end else if (btn_drop) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (w_down_ok) w_pr_nxt = r_pr + 5'd1;
                else           w_state_nxt = ST_LOCK;
            end
            ST_LOCK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_x_nxt = 10'(FIELD_X0 + CELL * 32'(w_pc_nxt));
        w_y_nxt = 10'(FIELD_Y0 + CELL * 32'(w_pr_nxt));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_pc    <= SPAWN_COL;
            r_pr    <= SPAWN_ROW;
            r_cnt   <= '0;
            r_x     <= 10'(FIELD_X0 + CELL * 32'(SPAWN_COL));
            r_y     <= 10'(FIELD_Y0 + CELL * 32'(SPAWN_ROW));
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_pc    <= w_pc_nxt;
            r_pr    <= w_pr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign spawn_ready    = (r_state == ST_IDLE);
    assign landed         = (r_state == ST_LOCK);
    assign x_shape        = r_x;
    assign y_shape        = r_y;
    assign blockNeighbors = r_mask;

endmodule

// File: tb/tb_shape_driver.sv
// Self-checking bench for shape_driver: directed scenarios plus random play against a cell-level model.
module tb_shape_driver;

    localparam int FT   = 2;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int CELL = 16;
    localparam int X0   = 240;
    localparam int Y0   = 80;

    localparam int P_WAIT = 0;
    localparam int P_FALL = 1;
    localparam int P_HARD = 2;
    localparam int P_LAND = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       spawn_valid = 1'b0;
    logic [8:0] spawn_shape = '0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_rot = 1'b0;
    logic       btn_drop = 1'b0;
    logic       spawn_ready;
    logic [9:0] x_shape;
    logic [9:0] y_shape;
    logic [8:0] blockNeighbors;
    logic       landed;

    shape_driver #(.FALL_TICKS(FT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .spawn_valid   (spawn_valid),
        .spawn_shape   (spawn_shape),
        .spawn_ready   (spawn_ready),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_rot       (btn_rot),
        .btn_drop      (btn_drop),
        .x_shape       (x_shape),
        .y_shape       (y_shape),
        .blockNeighbors(blockNeighbors),
        .landed        (landed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    int         m_phase;
    int         m_col;
    int         m_row;
    int         m_ticks;
    logic [8:0] m_mask;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Quarter turn clockwise: cell (dx,dy) moves to (-dy,dx).
    function automatic logic [8:0] turn(input logic [8:0] m);
        logic [8:0] r;
        r = '0;
        for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
                if (m[3*(dx+1)+(dy+1)]) r[3*(-dy+1)+(dx+1)] = 1'b1;
        return r;
    endfunction

    function automatic bit fits(input logic [8:0] m, input int c, input int r);
        if (c < 0 || c >= COLS || r < 0 || r >= ROWS) return 1'b0;
        for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
                if (m[3*(dx+1)+(dy+1)])
                    if (c+dx < 0 || c+dx >= COLS || r+dy < 0 || r+dy >= ROWS) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = P_WAIT;
        m_col   = 4;
        m_row   = 1;
        m_ticks = 0;
        m_mask  = '0;
    endtask

    task automatic model_step(input bit v, input logic [8:0] sh, input bit tk,
                              input bit l, input bit r, input bit ro, input bit d);
        bit fall;
        case (m_phase)
            P_WAIT: if (v && sh != '0) begin
                m_mask = sh; m_col = 4; m_row = 1; m_ticks = 0; m_phase = P_FALL;
            end
            P_FALL: begin
                fall = 1'b0;
                if (tk) begin
                    m_ticks++;
                    if (m_ticks == FT) begin m_ticks = 0; fall = 1'b1; end
                end
                if (fall) begin
                    if (fits(m_mask, m_col, m_row + 1)) m_row++;
                    else m_phase = P_LAND;
                end else if (ro) begin
                    if (fits(turn(m_mask), m_col, m_row)) m_mask = turn(m_mask);
                end else if (l) begin
                    if (fits(m_mask, m_col - 1, m_row)) m_col--;
                end else if (r) begin
                    if (fits(m_mask, m_col + 1, m_row)) m_col++;
                end else if (d) begin
                    m_phase = P_HARD;
                end
            end
            P_HARD: begin
                if (fits(m_mask, m_col, m_row + 1)) m_row++;
                else m_phase = P_LAND;
            end
            default: m_phase = P_WAIT;
        endcase
    endtask

    task automatic step(input bit v, input logic [8:0] sh, input bit tk,
                        input bit l, input bit r, input bit ro, input bit d);
        spawn_valid = v; spawn_shape = sh; tick = tk;
        btn_left = l; btn_right = r; btn_rot = ro; btn_drop = d;
        @(posedge clk);
        if (rst_n) model_step(v, sh, tk, l, r, ro, d);
        else       model_reset();
        #1;
        spawn_valid = 1'b0; spawn_shape = '0; tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_rot = 1'b0; btn_drop = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready",  int'(spawn_ready),    int'(m_phase == P_WAIT));
            chk("landed", int'(landed),         int'(m_phase == P_LAND));
            chk("x",      int'(x_shape),        X0 + CELL * m_col);
            chk("y",      int'(y_shape),        Y0 + CELL * m_row);
            chk("mask",   int'(blockNeighbors), int'(m_mask));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("rst_ready",  int'(spawn_ready),    1);
        chk("rst_landed", int'(landed),         0);
        chk("rst_x",      int'(x_shape),        304);
        chk("rst_y",      int'(y_shape),        96);
        chk("rst_mask",   int'(blockNeighbors), 0);

        // Vertical bar spawn
        step(1'b1, 9'h038, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("spawn_ready_low", int'(spawn_ready),    0);
        chk("spawn_x",         int'(x_shape),        304);
        chk("spawn_y",         int'(y_shape),        96);
        chk("spawn_mask",      int'(blockNeighbors), 'h038);

        // Left to the wall, fifth press ignored
        repeat (4) step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("left4_x", int'(x_shape), 240);
        step(1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("left5_x", int'(x_shape), 240);

        // Rotation blocked at the wall, allowed at column 4
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rot_wall_mask", int'(blockNeighbors), 'h038);
        repeat (4) step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("right4_x", int'(x_shape), 304);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rot_mask", int'(blockNeighbors), 'h092);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rot_back_mask", int'(blockNeighbors), 'h038);

        // Hard drop to the floor
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            idle();
            if (landed) got = 1'b1;
        end
        chk("drop_lock_seen", int'(got), 1);
        chk("drop_lock_y",    int'(y_shape), 368);
        idle();
        chk("post_lock_ready",  int'(spawn_ready), 1);
        chk("post_lock_landed", int'(landed),      0);

        // Gravity with FALL_TICKS=2; right on the stepping tick is dropped
        step(1'b1, 9'h038, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tick1_y", int'(y_shape), 96);
        step(1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("tick2_y", int'(y_shape), 112);
        chk("tick2_x", int'(x_shape), 304);
        step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tick4_y", int'(y_shape), 128);
        chk("tick4_x", int'(x_shape), 304);

        // Land it, then offer a zero mask: consumed, shape held
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40 && !spawn_ready; i++) idle();
        chk("drain1_ready", int'(spawn_ready), 1);
        step(1'b1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("zero_spawn_ready", int'(spawn_ready),    1);
        chk("zero_spawn_mask",  int'(blockNeighbors), 'h038);
        chk("zero_spawn_y",     int'(y_shape),        368);

        // Random play
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] sh;
            sh = ($urandom % 8 == 0) ? 9'h000 : 9'($urandom);
            step($urandom % 3 == 0, sh, $urandom % 3 == 0,
                 $urandom % 8 == 0, $urandom % 8 == 0,
                 $urandom % 8 == 0, $urandom % 10 == 0);
        end

        // Asynchronous reset in the middle of a hard drop
        for (int i = 0; i < 80 && !spawn_ready; i++)
            step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("drain2_ready", int'(spawn_ready), 1);
        step(1'b1, 9'h038, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_x",      int'(x_shape),        304);
        chk("arst_y",      int'(y_shape),        96);
        chk("arst_mask",   int'(blockNeighbors), 0);
        chk("arst_landed", int'(landed),         0);
        chk("arst_ready",  int'(spawn_ready),    1);
        repeat (3) begin
            idle();
            chk("arst_hold_landed", int'(landed), 0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            idle();
            chk("arst_after_landed", int'(landed), 0);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shape_driver.md
SHAPE_DRIVER -- requirements
Module: shape_driver

Interface
REQ-001 Parameter CELL, default 16: cell pitch in pixels.
REQ-002 Parameter FIELD_X0, default 240: playfield left edge, pixels.
REQ-003 Parameter FIELD_Y0, default 80: playfield top edge, pixels.
REQ-004 Parameter COLS, default 10; ROWS, default 20: playfield size in cells.
REQ-005 Parameter FALL_TICKS, default 30: tick pulses per gravity step.
REQ-006 Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle frame pulse.
- spawn_valid  in  1  new shape offered.
- spawn_shape  in  9  offered 3x3 mask.
- spawn_ready  out  1  shape accepted this cycle when valid.
- btn_left, btn_right, btn_rot, btn_drop  in  1 each  one-cycle command pulses.
- x_shape, y_shape  out  10 each  pivot cell top-left pixel.
- blockNeighbors  out  9  current 3x3 mask.
- landed  out  1  one-cycle pulse on lock.

REQ-007 Mask bit 3*(dx+1)+(dy+1) SHALL represent the cell at pivot offset (dx*CELL, dy*CELL), with dx, dy in {-1, 0, +1}. This is the encoding the display side decodes.

Function
REQ-008 States SHALL be IDLE, ACTIVE, DROP, LOCK.
REQ-009 spawn_ready SHALL be 1 only in IDLE.
REQ-010 IDLE with spawn_valid and a nonzero spawn_shape: load the mask, pc=4, pr=1, clear the gravity counter, go to ACTIVE.
REQ-011 IDLE with a zero spawn_shape: consume it (ready=1), stay in IDLE.
REQ-012 Internal pivot column pc (4b) and row pr (5b). Outputs registered:
- x_shape = FIELD_X0 + CELL*pc
- y_shape = FIELD_Y0 + CELL*pr
- both computed at 10-bit width.
REQ-013 Extents from the mask:
- L = |bits[2:0]
- R = |bits[8:6]
- T = bit0 | bit3 | bit6
- B = bit2 | bit5 | bit8
REQ-014 A position is legal iff all hold: pc >= L, pc+R <= COLS-1, pr >= T, pr+B <= ROWS-1.
REQ-015 ACTIVE gravity: count tick pulses; on the FALL_TICKS-th tick, reset the counter and attempt pr+1.
- Legal: move down.
- Illegal: go to LOCK.
REQ-016 ACTIVE commands, when no gravity step is due this cycle, priority rot > left > right > drop, one per cycle:
- left/right: pc-1 / pc+1 if legal, else ignore.
- rot: clockwise permutation new[6,3,0,7,4,1,8,5,2] = old[0..8], applied only if legal at the same pivot (no wall kick).
- drop: go to DROP.
REQ-017 A gravity step and a command in the same cycle: the gravity step wins; the command is dropped.
REQ-018 DROP: pr+1 every clock while legal; ignore all commands and tick; at the first illegal step go to LOCK.
REQ-019 LOCK, one cycle:
- landed=1.
- Mask and position hold.
- Next state IDLE.
REQ-020 The mask and position SHALL hold in IDLE until the next accepted spawn.
REQ-021 Latency: a command or step is visible on the outputs in the cycle after it is sampled.

Reset
REQ-022 rst_n low SHALL asynchronously force:
- state IDLE, pc=4, pr=1
- blockNeighbors=0, landed=0, gravity counter=0
- x_shape = FIELD_X0+64, y_shape = FIELD_Y0+16
REQ-023 Reset mid-ACTIVE or mid-DROP SHALL abandon the shape with no landed pulse.
REQ-024 After rst_n deasserts, spawn_ready SHALL be 1 in the first cycle.

Structure
REQ-025 A shared package SHALL hold:
- the state enum;
- CELL, FIELD_X0, FIELD_Y0, COLS, ROWS;
- the rotation permutation as a function.
REQ-026 One sub-module, shape_bounds, SHALL be combinational: mask, pc, pr -> legal flag. It is instantiated for the down, left, right and rotate candidates.
REQ-027 All other logic SHALL be in shape_driver.

Verification
REQ-028 Spawn mask 9'b000_111_000 (vertical bar) -> spawn_ready=1 for one cycle; next cycle x_shape=304, y_shape=96, blockNeighbors=0x038.
REQ-029 Issue 5 btn_left pulses after that spawn -> pc stops at 0, giving x_shape=240 after the 4th pulse; the 5th pulse is ignored.
REQ-030 Shape 0x038 at pc=0 + btn_rot -> mask would become 0x092 needing column -1: illegal; mask stays 0x038. At pc=4 the same btn_rot -> mask=0x092.
REQ-031 btn_drop with 0x038 at pr=1 -> pr increments each clock to 18, then LOCK: landed=1 for one cycle, y_shape=368, then spawn_ready=1.
REQ-032 FALL_TICKS=2: 4 tick pulses in ACTIVE -> pr goes 1->3; btn_right coincident with the 2nd tick is ignored.
REQ-033 rst_n low during DROP -> outputs go immediately to reset values; landed is never asserted.
